flit_link_tx: RTL and testbench

//  Output stage placed directly downstream of an input circular buffer. Pops flits from the buffer
//  and drives them onto the inter-router link under credit-based flow control. Keeps one credit
//  per free slot of the downstream buffer and checks head/body/tail packet framing.

---
 rtl/flit_link_tx.sv | 111 +++++++++++
 tb/tb_flit_link_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/flit_link_tx.sv
// Link output stage: pops flits from the upstream buffer and drives them onto the
// inter-router link under credit-based flow control, checking HEAD/BODY/TAIL framing.
module flit_link_tx #(
  parameter int FLIT_SIZE = 8,
  parameter int CREDITS   = 8,
  localparam int CNT_W    = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 empty_i,
  output logic                 read_o,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 valid_o,
  input  logic                 credit_i,
  output logic [CNT_W-1:0]     credit_cnt_o,
  output logic                 in_packet_o,
  output logic                 error_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    T_HEAD     = 2'b00,
    T_BODY     = 2'b01,
    T_TAIL     = 2'b10,
    T_HEADTAIL = 2'b11
  } flit_type_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  state_t           state_q, state_d;
  logic             send;
  logic             frame_err;
  logic             credit_ovf;
  logic [CNT_W-1:0] cnt_d;
  flit_type_t       ftype;

  // The send decision uses the registered count, so a credit arriving at zero
  // only enables a send on the following cycle.
  assign send   = ~rst & ~empty_i & (credit_cnt_o != '0);
  assign read_o = send;
  assign ftype  = flit_type_t'(data_i[FLIT_SIZE-1:FLIT_SIZE-2]);

  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (send) begin
      unique case (state_q)
        IDLE: begin
          unique case (ftype)
            T_HEAD:     state_d = IN_PKT;
            T_HEADTAIL: state_d = IDLE;
            default:    frame_err = 1'b1;
          endcase
        end
        IN_PKT: begin
          unique case (ftype)
            T_BODY: state_d = IN_PKT;
            T_TAIL: state_d = IDLE;
            T_HEAD: frame_err = 1'b1;
            default: begin
              state_d   = IDLE;
              frame_err = 1'b1;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A credit returned while already full saturates and is flagged as an overflow.
  always_comb begin
    cnt_d      = credit_cnt_o;
    credit_ovf = 1'b0;
    if (send && !credit_i) begin
      cnt_d = credit_cnt_o - 1'b1;
    end else if (!send && credit_i) begin
      if (credit_cnt_o == CNT_MAX) begin
        credit_ovf = 1'b1;
      end else begin
        cnt_d = credit_cnt_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flit_o       <= '0;
      valid_o      <= 1'b0;
      credit_cnt_o <= CNT_MAX;
      error_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_o      <= send;
      credit_cnt_o <= cnt_d;
      error_o      <= error_o | frame_err | credit_ovf;
      if (send) begin
        flit_o <= data_i;
      end
    end
  end

  assign in_packet_o = (state_q == IN_PKT);

endmodule

// File: tb/tb_flit_link_tx.sv
// Randomized and directed bench for flit_link_tx against a behavioural link model.
module tb_flit_link_tx;

  localparam int FLIT_SIZE = 8;
  localparam int CREDITS   = 8;
  localparam int CNT_W     = $clog2(CREDITS + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [FLIT_SIZE-1:0] data_i = '0;
  logic                 empty_i = 1'b1;
  logic                 read_o;
  logic [FLIT_SIZE-1:0] flit_o;
  logic                 valid_o;
  logic                 credit_i = 1'b0;
  logic [CNT_W-1:0]     credit_cnt_o;
  logic                 in_packet_o;
  logic                 error_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers and flags.
  int                   m_cnt;
  bit                   m_inpkt;
  bit                   m_err;
  bit                   m_valid;
  logic [FLIT_SIZE-1:0] m_flit;

  flit_link_tx #(.FLIT_SIZE(FLIT_SIZE), .CREDITS(CREDITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .empty_i     (empty_i),
    .read_o      (read_o),
    .flit_o      (flit_o),
    .valid_o     (valid_o),
    .credit_i    (credit_i),
    .credit_cnt_o(credit_cnt_o),
    .in_packet_o (in_packet_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the pop strobe, advance the model, check outputs.
  task automatic applyStimulus(input logic r, input logic e, input logic [FLIT_SIZE-1:0] d,
                               input logic c);
    bit       exp_send;
    bit [1:0] t;
    @(negedge clk);
    rst      = r;
    empty_i  = e;
    data_i   = d;
    credit_i = c;
    #1;
    exp_send = !r && !e && (m_cnt > 0);
    checkOutput("read_o", read_o, exp_send);
    @(posedge clk);
    if (r) begin
      m_flit  = '0;
      m_valid = 0;
      m_cnt   = CREDITS;
      m_inpkt = 0;
      m_err   = 0;
    end else begin
      m_valid = exp_send;
      if (exp_send) begin
        m_flit = d;
        t = d[FLIT_SIZE-1:FLIT_SIZE-2];
        if (!m_inpkt) begin
          if (t == 2'd0) m_inpkt = 1;
          else if (t != 2'd3) m_err = 1;
        end else begin
          if (t == 2'd2) m_inpkt = 0;
          else if (t == 2'd0) m_err = 1;
          else if (t == 2'd3) begin
            m_inpkt = 0;
            m_err   = 1;
          end
        end
      end
      m_cnt = m_cnt - int'(exp_send) + int'(c);
      if (m_cnt > CREDITS) begin
        m_cnt = CREDITS;
        m_err = 1;
      end
    end
    #1;
    checkOutput("flit_o", flit_o, m_flit);
    checkOutput("valid_o", valid_o, m_valid);
    checkOutput("credit_cnt_o", credit_cnt_o, m_cnt);
    checkOutput("in_packet_o", in_packet_o, m_inpkt);
    checkOutput("error_o", error_o, m_err);
  endtask

  initial begin
    m_cnt   = CREDITS;
    m_inpkt = 0;
    m_err   = 0;
    m_valid = 0;
    m_flit  = '0;

    // Reset state
    applyStimulus(1, 1, 8'h00, 0);
    applyStimulus(1, 1, 8'h00, 0);
    checkOutput("reset_cnt", credit_cnt_o, 8);
    checkOutput("reset_valid", valid_o, 0);

    // H, B, T packet with no returned credits
    applyStimulus(0, 0, 8'h01, 0);
    applyStimulus(0, 0, 8'h42, 0);
    applyStimulus(0, 0, 8'h83, 0);
    checkOutput("hbt_cnt", credit_cnt_o, 5);
    checkOutput("hbt_flit", flit_o, 8'h83);
    applyStimulus(0, 1, 8'h00, 0);

    // Ten single-flit packets drain all credits, then one credit at zero
    applyStimulus(1, 1, 8'h00, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 8'hC0 | 8'(i), 0);
    checkOutput("drain_cnt", credit_cnt_o, 0);
    checkOutput("drain_flit", flit_o, 8'hC7);
    applyStimulus(0, 0, 8'hCA, 1);
    checkOutput("zero_credit_cnt", credit_cnt_o, 1);
    applyStimulus(0, 0, 8'hCB, 0);
    checkOutput("post_credit_cnt", credit_cnt_o, 0);
    checkOutput("post_credit_flit", flit_o, 8'hCB);

    // Streaming with a credit every cycle holds the count at 3
    applyStimulus(1, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'hD0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 8'hE0 | 8'(i), 1);
    checkOutput("stream_cnt", credit_cnt_o, 3);

    // Credit overflow at full count is sticky
    applyStimulus(1, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("ovf_cnt", credit_cnt_o, 8);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h00, 0);
    checkOutput("ovf_sticky", error_o, 1);

    // BODY while idle is forwarded and flagged; reset mid-packet clears everything
    applyStimulus(1, 1, 8'h00, 0);
    applyStimulus(0, 0, 8'h55, 0);
    checkOutput("body_idle_valid", valid_o, 1);
    checkOutput("body_idle_err", error_o, 1);
    applyStimulus(0, 0, 8'h11, 0);
    applyStimulus(0, 0, 8'h66, 0);
    applyStimulus(1, 0, 8'h77, 0);
    checkOutput("rst_mid_inpkt", in_packet_o, 0);
    checkOutput("rst_mid_err", error_o, 0);
    checkOutput("rst_mid_cnt", credit_cnt_o, 8);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 2) == 0),
                    FLIT_SIZE'($urandom_range(0, 255)),
                    ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
